// File: rtl/pong_match_ctrl_if.sv
// Pong match controller signal bundle.
// Keyboard/point events in, ball control and score/state display out.
interface pong_match_ctrl_if;
    logic [7:0] keycode;
    logic       point_left;
    logic       point_right;
    logic       ball_enable;
    logic       ball_hold;
    logic       serve_dir;
    logic [3:0] score_l;
    logic [3:0] score_r;
    logic [1:0] winner;
    logic [2:0] state;
    logic [7:0] timer;

    modport master (
        output keycode, point_left, point_right,
        input  ball_enable, ball_hold, serve_dir,
        input  score_l, score_r, winner, state, timer
    );

    modport slave (
        input  keycode, point_left, point_right,
        output ball_enable, ball_hold, serve_dir,
        output score_l, score_r, winner, state, timer
    );
endinterface

// File: rtl/pong_match_ctrl.sv
// Pong match-level sequencer: serve countdown, point freeze,
// pause toggle and win detection. All outputs are registered.
module pong_match_ctrl #(
    parameter logic [3:0] WIN_SCORE    = 4'd7,
    parameter logic [7:0] SERVE_FRAMES = 8'd60,
    parameter logic [7:0] POINT_FRAMES = 8'd30,
    parameter logic [7:0] START_KEY    = 8'h2C,
    parameter logic [7:0] PAUSE_KEY    = 8'h13
) (
    input  logic frame_clk,
    input  logic Reset,
    pong_match_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SERVE  = 3'd1,
        RALLY  = 3'd2,
        POINT  = 3'd3,
        PAUSED = 3'd4,
        OVER   = 3'd5
    } state_t;

    state_t     st_q, st_d;
    logic [7:0] prev_q;
    logic [3:0] sl_q, sl_d;
    logic [3:0] sr_q, sr_d;
    logic [1:0] win_q, win_d;
    logic       dir_q, dir_d;
    logic [7:0] tmr_q, tmr_d;
    logic       en_q, en_d;
    logic       hold_q, hold_d;

    logic       start_ev;
    logic       pause_ev;
    logic [3:0] sl_inc;
    logic [3:0] sr_inc;

    // A press fires only on the edge where the key first appears.
    assign start_ev = (bus.keycode == START_KEY) && (prev_q != START_KEY);
    assign pause_ev = (bus.keycode == PAUSE_KEY) && (prev_q != PAUSE_KEY);
    assign sl_inc   = sl_q + 4'd1;
    assign sr_inc   = sr_q + 4'd1;

    // State register plus every registered output.
    always_ff @(posedge frame_clk or negedge Reset) begin
        if (!Reset) begin
            st_q   <= IDLE;
            prev_q <= 8'h00;
            sl_q   <= 4'd0;
            sr_q   <= 4'd0;
            win_q  <= 2'b00;
            dir_q  <= 1'b0;
            tmr_q  <= 8'd0;
            en_q   <= 1'b0;
            hold_q <= 1'b1;
        end else begin
            st_q   <= st_d;
            prev_q <= bus.keycode;
            sl_q   <= sl_d;
            sr_q   <= sr_d;
            win_q  <= win_d;
            dir_q  <= dir_d;
            tmr_q  <= tmr_d;
            en_q   <= en_d;
            hold_q <= hold_d;
        end
    end

    // Next-state and next-output logic for the match sequence.
    always_comb begin
        st_d  = st_q;
        sl_d  = sl_q;
        sr_d  = sr_q;
        win_d = win_q;
        dir_d = dir_q;
        tmr_d = tmr_q;
        case (st_q)
            IDLE: begin
                tmr_d = 8'd0;
                if (start_ev) begin
                    st_d  = SERVE;
                    sl_d  = 4'd0;
                    sr_d  = 4'd0;
                    win_d = 2'b00;
                    dir_d = 1'b0;
                    tmr_d = SERVE_FRAMES - 8'd1;
                end
            end
            SERVE: begin
                if (tmr_q == 8'd0) begin
                    st_d = RALLY;
                end else begin
                    tmr_d = tmr_q - 8'd1;
                end
            end
            RALLY: begin
                tmr_d = 8'd0;
                if (bus.point_left) begin
                    sl_d  = sl_inc;
                    dir_d = 1'b1;
                    if (sl_inc == WIN_SCORE) begin
                        st_d  = OVER;
                        win_d = 2'b01;
                    end else begin
                        st_d  = POINT;
                        tmr_d = POINT_FRAMES - 8'd1;
                    end
                end else if (bus.point_right) begin
                    sr_d  = sr_inc;
                    dir_d = 1'b0;
                    if (sr_inc == WIN_SCORE) begin
                        st_d  = OVER;
                        win_d = 2'b10;
                    end else begin
                        st_d  = POINT;
                        tmr_d = POINT_FRAMES - 8'd1;
                    end
                end else if (pause_ev) begin
                    st_d = PAUSED;
                end
            end
            POINT: begin
                if (tmr_q == 8'd0) begin
                    st_d  = SERVE;
                    tmr_d = SERVE_FRAMES - 8'd1;
                end else begin
                    tmr_d = tmr_q - 8'd1;
                end
            end
            PAUSED: begin
                tmr_d = 8'd0;
                if (pause_ev) begin
                    st_d = RALLY;
                end
            end
            OVER: begin
                tmr_d = 8'd0;
                if (start_ev) begin
                    st_d  = SERVE;
                    sl_d  = 4'd0;
                    sr_d  = 4'd0;
                    win_d = 2'b00;
                    dir_d = (win_q == 2'b01);
                    tmr_d = SERVE_FRAMES - 8'd1;
                end
            end
            default: begin
                st_d  = IDLE;
                tmr_d = 8'd0;
            end
        endcase
    end

    // Ball controls follow the state being entered.
    always_comb begin
        en_d   = 1'b0;
        hold_d = 1'b1;
        case (st_d)
            RALLY: begin
                en_d   = 1'b1;
                hold_d = 1'b0;
            end
            PAUSED: begin
                hold_d = 1'b0;
            end
            default: begin
                en_d   = 1'b0;
                hold_d = 1'b1;
            end
        endcase
    end

    assign bus.ball_enable = en_q;
    assign bus.ball_hold   = hold_q;
    assign bus.serve_dir   = dir_q;
    assign bus.score_l     = sl_q;
    assign bus.score_r     = sr_q;
    assign bus.winner      = win_q;
    assign bus.state       = st_q;
    assign bus.timer       = tmr_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Testbench for pong_match_ctrl: directed scenarios plus random
// key/point traffic compared against a rule-level match model.
module tb_pong_match_ctrl;

    localparam int WIN = 3;
    localparam int SF  = 60;
    localparam int PF  = 30;
    localparam logic [7:0] KS = 8'h2C;
    localparam logic [7:0] KP = 8'h13;

    logic frame_clk = 1'b0;
    logic Reset     = 1'b0;

    pong_match_ctrl_if bus ();

    pong_match_ctrl #(
        .WIN_SCORE    (4'd3),
        .SERVE_FRAMES (8'd60),
        .POINT_FRAMES (8'd30),
        .START_KEY    (8'h2C),
        .PAUSE_KEY    (8'h13)
    ) dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .bus       (bus.master)
    );

    always #5 frame_clk = ~frame_clk;

    int checks   = 0;
    int failures = 0;

    // Match model: plain integers driven by the rule list.
    int m_st, m_sl, m_sr, m_win, m_dir, m_tmr;
    logic [7:0] m_prev;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_sl = 0; m_sr = 0; m_win = 0;
        m_dir = 0; m_tmr = 0; m_prev = 8'h00;
    endtask

    task automatic model_step(input logic [7:0] kc,
                              input bit pl, input bit pr);
        bit st, pz;
        st = (kc == KS) && (m_prev != KS);
        pz = (kc == KP) && (m_prev != KP);
        m_prev = kc;
        if (m_st == 0) begin
            if (st) begin
                m_st = 1; m_sl = 0; m_sr = 0; m_win = 0;
                m_dir = 0; m_tmr = SF - 1;
            end
        end else if (m_st == 1) begin
            if (m_tmr == 0) m_st = 2;
            else m_tmr = m_tmr - 1;
        end else if (m_st == 2) begin
            if (pl) begin
                m_sl = m_sl + 1;
                m_dir = 1;
                if (m_sl == WIN) begin m_st = 5; m_win = 1; end
                else begin m_st = 3; m_tmr = PF - 1; end
            end else if (pr) begin
                m_sr = m_sr + 1;
                m_dir = 0;
                if (m_sr == WIN) begin m_st = 5; m_win = 2; end
                else begin m_st = 3; m_tmr = PF - 1; end
            end else if (pz) begin
                m_st = 4;
            end
        end else if (m_st == 3) begin
            if (m_tmr == 0) begin m_st = 1; m_tmr = SF - 1; end
            else m_tmr = m_tmr - 1;
        end else if (m_st == 4) begin
            if (pz) m_st = 2;
        end else if (m_st == 5) begin
            if (st) begin
                m_dir = (m_win == 1) ? 1 : 0;
                m_st = 1; m_sl = 0; m_sr = 0; m_win = 0;
                m_tmr = SF - 1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".state"},  int'(bus.state),       m_st);
        chk({tag, ".sl"},     int'(bus.score_l),     m_sl);
        chk({tag, ".sr"},     int'(bus.score_r),     m_sr);
        chk({tag, ".win"},    int'(bus.winner),      m_win);
        chk({tag, ".dir"},    int'(bus.serve_dir),   m_dir);
        chk({tag, ".timer"},  int'(bus.timer),       m_tmr);
        chk({tag, ".enable"}, int'(bus.ball_enable), (m_st == 2) ? 1 : 0);
        chk({tag, ".hold"},   int'(bus.ball_hold),
            (m_st == 2 || m_st == 4) ? 0 : 1);
    endtask

    task automatic step(input string tag, input logic [7:0] kc,
                        input bit pl, input bit pr);
        @(negedge frame_clk);
        bus.keycode     = kc;
        bus.point_left  = pl;
        bus.point_right = pr;
        model_step(kc, pl, pr);
        @(posedge frame_clk);
        #1;
        check_all(tag);
    endtask

    task automatic run_until(input string tag, input int target,
                             input int budget);
        int n;
        n = 0;
        while (m_st != target && n < budget) begin
            step(tag, 8'h00, 1'b0, 1'b0);
            n++;
        end
        checks++;
        assert (m_st == target) else begin
            failures++;
            $error("FAIL %s timeout observed_state=%0d expected=%0d",
                   tag, m_st, target);
        end
    endtask

    initial begin
        int n;
        logic [7:0] kc;
        bus.keycode     = 8'h00;
        bus.point_left  = 1'b0;
        bus.point_right = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        @(negedge frame_clk);
        Reset = 1'b1;

        // Start held for five frames gives one event.
        for (int i = 0; i < 5; i++) step("start", KS, 1'b0, 1'b0);
        chk("start.once_serve", int'(bus.state), 1);
        n = 0;
        while (m_st == 1 && n < 100) begin
            step("serve", 8'h00, 1'b0, 1'b0);
            n++;
        end
        chk("serve.dwell", n + 4, SF);
        chk("serve.rally", int'(bus.state), 2);

        // Point to the right player, freeze then serve again.
        step("pt_r", 8'h00, 1'b0, 1'b1);
        chk("pt_r.score", int'(bus.score_r), 1);
        run_until("pt_r.to_serve", 1, 40);
        run_until("pt_r.to_rally", 2, 70);

        // Both points and a pause on the same edge.
        step("simul", KP, 1'b1, 1'b1);
        chk("simul.state", int'(bus.state), 3);
        chk("simul.sl", int'(bus.score_l), 1);
        run_until("simul.back", 2, 100);

        // Pause toggle, points ignored while paused.
        step("pause", KP, 1'b0, 1'b0);
        step("paused.pt", 8'h00, 1'b1, 1'b0);
        step("paused.start", KS, 1'b0, 1'b0);
        step("resume", KP, 1'b0, 1'b0);
        chk("resume.state", int'(bus.state), 2);

        // Left player wins the match.
        n = 0;
        while (m_st != 5 && n < 10) begin
            run_until("win.rally", 2, 100);
            step("win.pt", 8'h00, 1'b1, 1'b0);
            n++;
        end
        chk("win.winner", int'(bus.winner), 1);
        chk("win.sl", int'(bus.score_l), WIN);
        step("over.idle", 8'h00, 1'b0, 1'b0);
        step("over.start", KS, 1'b0, 1'b0);
        chk("over.dir", int'(bus.serve_dir), 1);

        // Asynchronous reset during SERVE at timer 20.
        run_until("rst.serve", 1, 10);
        n = 0;
        while (m_tmr != 20 && n < 100) begin
            step("rst.wait", 8'h00, 1'b0, 1'b0);
            n++;
        end
        #2;
        Reset = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        #1;
        Reset = 1'b1;

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            case ($urandom_range(0, 7))
                0, 1:    kc = KS;
                2, 3:    kc = KP;
                4:       kc = 8'($urandom);
                default: kc = 8'h00;
            endcase
            step("rand", kc, ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 5) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pong_match_ctrl.md
Name: pong_match_ctrl

Overview:
- Match-level sequencer for the Pong datapath. It gates the ball motion block with run and hold controls.
- It runs serve countdowns, post-point pauses, player pause/resume and win detection from keyboard events and point pulses.
- It sits between the keycode decoder and the ball/paddle logic. Score and state outputs drive the on-screen text renderer.

Parameters:
- WIN_SCORE, 4'd7: score that ends the match. Legal range 1..15.
- SERVE_FRAMES, 8'd60: frames the ball is held at centre before a serve. Legal range 1..255.
- POINT_FRAMES, 8'd30: frames of freeze after a point is scored. Legal range 1..255.
- START_KEY, 8'h2C: keycode that starts or restarts the match (space).
- PAUSE_KEY, 8'h13: keycode that toggles pause ('P').

Ports:
- frame_clk  in  1  frame-rate clock (vsync); the only clock.
- Reset  in  1  asynchronous, active-low reset.
- keycode  in  8  current keycode; 8'h00 means no key.
- point_left  in  1  one-cycle pulse: left player scored (ball crossed the right goal).
- point_right  in  1  one-cycle pulse: right player scored.
- ball_enable  out  1  1 = ball integrates motion this frame.
- ball_hold  out  1  1 = ball forced to centre with zero Y motion.
- serve_dir  out  1  0 = serve toward the left player, 1 = toward the right player.
- score_l  out  4  left player score.
- score_r  out  4  right player score.
- winner  out  2  00 none, 01 left, 10 right.
- state  out  3  IDLE=0, SERVE=1, RALLY=2, POINT=3, PAUSED=4, OVER=5.
- timer  out  8  frames remaining in SERVE/POINT; 0 in other states.

Behaviour:
- All outputs are registered (Moore). A transition taken at edge N is visible on all outputs immediately after edge N.
- Reset low, asynchronously: state=IDLE, scores=0, winner=00, ball_enable=0, ball_hold=1, serve_dir=0, timer=0.
- Reset low mid-match: same values. Any in-flight timer or pause is abandoned.
- Key events: the block registers the previous keycode.
  - A press fires when keycode==K and prev!=K.
  - Holding a key produces exactly one event.
  - prev resets to 8'h00. A key already held as reset releases fires once on the first edge.
- IDLE: enable=0, hold=1.
  - START press → SERVE, scores=0, winner=00, serve_dir=0, timer=SERVE_FRAMES-1.
- SERVE: enable=0, hold=1.
  - timer decrements by 1 each frame.
  - Edge with timer==0 → RALLY.
  - Total dwell is exactly SERVE_FRAMES frames.
  - Keys and points are ignored.
- RALLY: enable=1, hold=0. Priority order:
  1. point_left: score_l+1.
     - If the new value equals WIN_SCORE → OVER, winner=01.
     - Otherwise → POINT with timer=POINT_FRAMES-1.
     - serve_dir=1 (serve toward the conceding right player).
  2. point_right: mirror of point_left (score_r, winner=10, serve_dir=0).
  3. PAUSE press → PAUSED.
- Simultaneous point_left and point_right: only point_left is applied; point_right is dropped.
- A point together with a PAUSE press: the point wins and the pause is dropped.
- POINT: enable=0, hold=1.
  - timer decrements each frame.
  - Edge with timer==0 → SERVE with timer=SERVE_FRAMES-1.
  - Points and keys are ignored.
- PAUSED: enable=0, hold=0 (ball frozen in place, not recentred).
  - PAUSE press → RALLY.
  - START and points are ignored.
- OVER: enable=0, hold=1. Scores and winner are frozen for display.
  - START press → SERVE with scores=0, winner=00, timer=SERVE_FRAMES-1.
  - serve_dir = 1 if winner was 01, 0 if winner was 10 (loser receives).
- Scores never exceed WIN_SCORE, since OVER is entered on reaching it. No 4-bit wrap is possible for legal parameters.
- timer is 0 in IDLE, RALLY, PAUSED and OVER.
- Undefined state encodings (6, 7) return to IDLE on the next edge with the IDLE output values.

Test Plan:
1. Reset then START: drop Reset low, release with keycode=00, hold keycode=2C for 5 frames → state 0→1 once, timer 59..0, state=2 after exactly 60 SERVE frames, enable=1, hold=0.
2. Point pause: in RALLY pulse point_right → score_r=1, state=3, serve_dir=0, hold=1. After 30 frames state=1, then 60 frames later state=2.
3. Simultaneous events: in RALLY assert point_left, point_right and a fresh 13 press on the same edge → score_l+1, score_r unchanged, state=3 (not 4).
4. Pause toggle: in RALLY press 13 → state=4, enable=0, hold=0. Pulse point_left while paused → scores unchanged. Press 13 again → state=2.
5. Win: WIN_SCORE=3, drive three point_left pulses (each after returning to RALLY) → score_l=3, winner=01, state=5. START → scores 0, winner 00, serve_dir=1, state=1.
6. Reset mid-SERVE: at timer=20 pulse Reset low for a partial cycle → outputs return to reset values immediately, asynchronously, without waiting for a frame_clk edge.
